// File: rtl/tx_stream_framer_if.sv
// Stream bundle for the TX framer: payload in with ready/valid, line words out.
// The framer takes the slave view; whatever feeds payload and watches the
// line takes the master view.
interface tx_stream_framer_if #(
    parameter int DATA_WIDTH = 80
);
    logic [DATA_WIDTH-1:0] DATA_IN;
    logic                  DATA_IN_VALID;
    logic                  DATA_IN_READY;
    logic [DATA_WIDTH-1:0] DATA_OUT;
    logic                  DATA_OUT_VALID;

    modport master (
        output DATA_IN,
        output DATA_IN_VALID,
        input  DATA_IN_READY,
        input  DATA_OUT,
        input  DATA_OUT_VALID
    );

    modport slave (
        input  DATA_IN,
        input  DATA_IN_VALID,
        output DATA_IN_READY,
        output DATA_OUT,
        output DATA_OUT_VALID
    );
endinterface

// File: rtl/tx_stream_framer.sv
// TX stream framer: after START it sends a block of training words, then a
// continuous stream of payload words (fill words when no payload is offered).
// Every word passes through a bit-delay stage (0-7 bits, carrying bits over
// from the previous word) and an XOR mask; OFFSET and MASK are captured at
// START. Word generation to DATA_OUT is a fixed two-register pipeline.
module tx_stream_framer #(
    parameter int                    DATA_WIDTH    = 80,
    parameter int                    TRAIN_WORDS   = 16,
    parameter logic [DATA_WIDTH-1:0] TRAIN_PATTERN = {40{2'b10}},
    parameter logic [DATA_WIDTH-1:0] FILL_WORD     = '0
) (
    input  logic                  USER_CLK,
    input  logic                  RESET_N,
    input  logic                  START,
    input  logic                  STOP,
    input  logic [2:0]            OFFSET,
    input  logic [DATA_WIDTH-1:0] MASK,
    tx_stream_framer_if.slave     bus,
    output logic                  TRAINING,
    output logic [15:0]           PAYLOAD_CNT,
    output logic [15:0]           FILL_CNT
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TRAIN  = 2'd1,
        STREAM = 2'd2
    } state_t;

    localparam int TCW = (TRAIN_WORDS > 1) ? $clog2(TRAIN_WORDS) : 1;
    localparam logic [TCW-1:0] TRAIN_LAST = TCW'((TRAIN_WORDS > 0) ? TRAIN_WORDS - 1 : 0);
    localparam int SHW = $clog2(DATA_WIDTH + 1);

    state_t                state;
    logic                  training_q;
    logic [TCW-1:0]        train_cnt;
    logic [2:0]            off_q;
    logic [DATA_WIDTH-1:0] mask_q;

    logic                  start_go;
    logic                  ready;
    logic                  accept;

    logic                  s1_valid;
    logic                  s1_fill;
    logic [DATA_WIDTH-1:0] s1_word;

    logic [DATA_WIDTH-1:0] cur_q;
    logic [DATA_WIDTH-1:0] prev_q;
    logic                  s2_valid;
    logic [SHW-1:0]        shamt;
    logic [DATA_WIDTH-1:0] shifted;

    logic [DATA_WIDTH-1:0] out_q;
    logic                  out_valid_q;
    logic [15:0]           payload_q;
    logic [15:0]           fill_q;

    // STOP beats START when both pulse together; payload is only taken in
    // STREAM and never in the cycle that is shutting the stream down.
    assign start_go = START && !STOP;
    assign ready    = (state == STREAM) && !STOP;
    assign accept   = bus.DATA_IN_VALID && ready;

    // Stage 1: pick this cycle's word from the current state.
    always_comb begin
        s1_valid = 1'b0;
        s1_fill  = 1'b0;
        s1_word  = '0;
        case (state)
            TRAIN: begin
                s1_valid = 1'b1;
                s1_word  = TRAIN_PATTERN;
            end
            STREAM: begin
                s1_valid = 1'b1;
                if (accept) begin
                    s1_word = bus.DATA_IN;
                end else begin
                    s1_word = FILL_WORD;
                    s1_fill = 1'b1;
                end
            end
            default: begin
                s1_valid = 1'b0;
            end
        endcase
    end

    // Sequencer: STOP returns to IDLE from an active state, START (re)starts
    // training and captures OFFSET/MASK, training ends after TRAIN_WORDS words.
    always_ff @(posedge USER_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state      <= IDLE;
            training_q <= 1'b0;
            train_cnt  <= '0;
            off_q      <= '0;
            mask_q     <= '0;
        end else if (STOP && state != IDLE) begin
            state      <= IDLE;
            training_q <= 1'b0;
        end else if (start_go) begin
            off_q     <= OFFSET;
            mask_q    <= MASK;
            train_cnt <= '0;
            if (TRAIN_WORDS == 0) begin
                state      <= STREAM;
                training_q <= 1'b0;
            end else begin
                state      <= TRAIN;
                training_q <= 1'b1;
            end
        end else if (state == TRAIN) begin
            if (train_cnt == TRAIN_LAST) begin
                state      <= STREAM;
                training_q <= 1'b0;
            end else begin
                train_cnt <= train_cnt + 1'b1;
            end
        end
    end

    // Payload and fill word counters, free-running 16-bit wrap, zeroed by START.
    always_ff @(posedge USER_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            payload_q <= '0;
            fill_q    <= '0;
        end else if (start_go) begin
            payload_q <= '0;
            fill_q    <= '0;
        end else begin
            if (accept) begin
                payload_q <= payload_q + 16'd1;
            end
            if (s1_fill) begin
                fill_q <= fill_q + 16'd1;
            end
        end
    end

    // Stage 2 registers: current word plus the word before it, whose top bits
    // feed the low end of the delayed word. A fresh START forgets the history.
    always_ff @(posedge USER_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            cur_q    <= '0;
            prev_q   <= '0;
            s2_valid <= 1'b0;
        end else begin
            cur_q    <= s1_word;
            prev_q   <= start_go ? '0 : cur_q;
            s2_valid <= s1_valid;
        end
    end

    // Bit delay: shifting {cur,prev} right by (width - offset) leaves cur moved
    // up by offset bits with prev's top bits underneath; offset 0 gives cur.
    always_comb begin
        shamt   = SHW'(DATA_WIDTH) - SHW'(off_q);
        shifted = DATA_WIDTH'({cur_q, prev_q} >> shamt);
    end

    // Output register: masked line word, held at zero whenever not valid.
    always_ff @(posedge USER_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= s2_valid;
            out_q       <= s2_valid ? (shifted ^ mask_q) : '0;
        end
    end

    assign bus.DATA_IN_READY  = ready;
    assign bus.DATA_OUT       = out_q;
    assign bus.DATA_OUT_VALID = out_valid_q;
    assign TRAINING           = training_q;
    assign PAYLOAD_CNT        = payload_q;
    assign FILL_CNT           = fill_q;

endmodule

// File: tb/tb_tx_stream_framer.sv
// Self-checking bench for tx_stream_framer: a behavioural model predicts each
// generated line word and its arrival cycle into a queue, and every cycle the
// DUT output is popped and compared against it.
module tb_tx_stream_framer;

    localparam int            DW   = 80;
    localparam int            TW   = 16;
    localparam logic [DW-1:0] PAT  = {40{2'b10}};
    localparam logic [DW-1:0] FILL = '0;

    logic            USER_CLK = 1'b0;
    logic            RESET_N  = 1'b0;
    logic            START    = 1'b0;
    logic            STOP     = 1'b0;
    logic [2:0]      OFFSET   = 3'd0;
    logic [DW-1:0]   MASK     = '0;
    logic            TRAINING;
    logic [15:0]     PAYLOAD_CNT;
    logic [15:0]     FILL_CNT;

    tx_stream_framer_if #(.DATA_WIDTH(DW)) bus ();

    tx_stream_framer #(
        .DATA_WIDTH    (DW),
        .TRAIN_WORDS   (TW),
        .TRAIN_PATTERN (PAT),
        .FILL_WORD     (FILL)
    ) dut (
        .USER_CLK    (USER_CLK),
        .RESET_N     (RESET_N),
        .START       (START),
        .STOP        (STOP),
        .OFFSET      (OFFSET),
        .MASK        (MASK),
        .bus         (bus),
        .TRAINING    (TRAINING),
        .PAYLOAD_CNT (PAYLOAD_CNT),
        .FILL_CNT    (FILL_CNT)
    );

    always #5 USER_CLK = ~USER_CLK;

    int cyc = 0;
    always @(posedge USER_CLK) cyc++;

    typedef enum int {M_IDLE, M_TRAIN, M_STREAM} mstate_t;
    typedef struct {
        logic [DW-1:0] word;
        int            stamp;
    } exp_t;

    mstate_t       mstate;
    int            mcnt;
    logic [2:0]    moff;
    logic [DW-1:0] mmask;
    logic [DW-1:0] mp;
    logic [15:0]   mpay;
    logic [15:0]   mfill;
    exp_t          q[$];

    int vectors     = 0;
    int miscompares = 0;
    int valid_seen  = 0;
    bit ready_seen  = 0;

    // Line word for generated word w with previous word p: w delayed by off
    // bits, p's top off bits filling the vacated low bits, then masked.
    function automatic logic [DW-1:0] line_word(input logic [DW-1:0] w, input logic [DW-1:0] p,
                                                input logic [2:0] off, input logic [DW-1:0] m);
        logic [2*DW-1:0] cat;
        cat = {w, p} >> (DW - int'(off));
        return cat[DW-1:0] ^ m;
    endfunction

    task automatic model_reset();
        mstate = M_IDLE;
        mcnt   = 0;
        moff   = '0;
        mmask  = '0;
        mp     = '0;
        mpay   = '0;
        mfill  = '0;
        q.delete();
    endtask

    // One clock of stimulus: predict, clock, then check the cycle's outputs.
    task automatic drive_cycle(input logic start, input logic stop,
                               input logic [DW-1:0] din, input logic dvalid);
        logic [DW-1:0] w;
        bit            gen, acc, fil, go;
        logic          exp_ready;
        exp_t          e;
        START             = start;
        STOP              = stop;
        bus.DATA_IN       = din;
        bus.DATA_IN_VALID = dvalid;
        #1;
        exp_ready = (mstate == M_STREAM) && !stop;
        vectors++;
        if (bus.DATA_IN_READY !== exp_ready) begin
            miscompares++;
            $display("[TB] FAIL ready: got %b expected %b cycle %0d", bus.DATA_IN_READY, exp_ready, cyc);
        end
        if (bus.DATA_IN_READY === 1'b1) ready_seen = 1;

        go  = start && !stop;
        gen = 0; acc = 0; fil = 0; w = '0;
        case (mstate)
            M_TRAIN: begin gen = 1; w = PAT; end
            M_STREAM: begin
                gen = 1;
                if (dvalid && !stop) begin w = din; acc = 1; end
                else begin w = FILL; fil = 1; end
            end
            default: ;
        endcase
        if (go) begin moff = OFFSET; mmask = MASK; mp = '0; end
        if (gen) begin
            e.word  = line_word(w, mp, moff, mmask);
            e.stamp = cyc + 2;
            q.push_back(e);
        end
        mp = w;
        if (go) begin mpay = '0; mfill = '0; end
        else begin
            if (acc) mpay++;
            if (fil) mfill++;
        end
        if (stop && mstate != M_IDLE) mstate = M_IDLE;
        else if (go) begin mcnt = 0; mstate = (TW == 0) ? M_STREAM : M_TRAIN; end
        else if (mstate == M_TRAIN) begin
            if (mcnt == TW - 1) mstate = M_STREAM;
            else mcnt++;
        end

        @(posedge USER_CLK);
        #1;
        vectors++;
        if (TRAINING !== (mstate == M_TRAIN)) begin
            miscompares++;
            $display("[TB] FAIL training: got %b expected %b cycle %0d", TRAINING, (mstate == M_TRAIN), cyc);
        end
        vectors++;
        if (PAYLOAD_CNT !== mpay) begin
            miscompares++;
            $display("[TB] FAIL payload_cnt: got %0d expected %0d cycle %0d", PAYLOAD_CNT, mpay, cyc);
        end
        vectors++;
        if (FILL_CNT !== mfill) begin
            miscompares++;
            $display("[TB] FAIL fill_cnt: got %0d expected %0d cycle %0d", FILL_CNT, mfill, cyc);
        end
        vectors++;
        if (bus.DATA_OUT_VALID === 1'b1) begin
            valid_seen++;
            if (q.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL unexpected_word: got %h with nothing expected cycle %0d", bus.DATA_OUT, cyc);
            end else begin
                e = q.pop_front();
                if (bus.DATA_OUT !== e.word || cyc != e.stamp) begin
                    miscompares++;
                    $display("[TB] FAIL line_word: got %h at cycle %0d expected %h at cycle %0d",
                             bus.DATA_OUT, cyc, e.word, e.stamp);
                end
            end
        end else begin
            if (bus.DATA_OUT !== '0 || (q.size() > 0 && q[0].stamp <= cyc)) begin
                miscompares++;
                $display("[TB] FAIL idle_out: got valid=%b data=%h expected pending=%0d cycle %0d",
                         bus.DATA_OUT_VALID, bus.DATA_OUT, q.size(), cyc);
                if (q.size() > 0 && q[0].stamp <= cyc) void'(q.pop_front());
            end
        end
    endtask

    task automatic expect_zero_outputs(input string tag);
        vectors++;
        if (bus.DATA_OUT !== '0 || bus.DATA_OUT_VALID !== 1'b0 || bus.DATA_IN_READY !== 1'b0 ||
            TRAINING !== 1'b0 || PAYLOAD_CNT !== 16'd0 || FILL_CNT !== 16'd0) begin
            miscompares++;
            $display("[TB] FAIL %s: got out=%h v=%b rdy=%b trn=%b pay=%0d fill=%0d expected all zero",
                     tag, bus.DATA_OUT, bus.DATA_OUT_VALID, bus.DATA_IN_READY, TRAINING, PAYLOAD_CNT, FILL_CNT);
        end
    endtask

    task automatic test_reset();
        RESET_N = 1'b0;
        #13;
        expect_zero_outputs("reset_state");
        @(negedge USER_CLK);
        RESET_N = 1'b1;
        @(posedge USER_CLK);
        #1;
        model_reset();
        valid_seen = 0;
        drive_cycle(1'b0, 1'b1, '0, 1'b0);
        for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b0, '0, 1'b0);
        vectors++;
        if (valid_seen != 0) begin
            miscompares++;
            $display("[TB] FAIL idle_after_reset: got %0d valid words expected 0", valid_seen);
        end
    endtask

    task automatic test_training();
        int th;
        OFFSET = 3'd0;
        MASK   = '0;
        drive_cycle(1'b1, 1'b0, '0, 1'b0);
        th = (TRAINING === 1'b1) ? 1 : 0;
        drive_cycle(1'b0, 1'b0, '0, 1'b0);
        if (TRAINING === 1'b1) th++;
        vectors++;
        if (bus.DATA_OUT_VALID !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL first_latency_early: got valid=%b expected 0", bus.DATA_OUT_VALID);
        end
        drive_cycle(1'b0, 1'b0, '0, 1'b0);
        if (TRAINING === 1'b1) th++;
        vectors++;
        if (bus.DATA_OUT_VALID !== 1'b1 || bus.DATA_OUT !== PAT) begin
            miscompares++;
            $display("[TB] FAIL first_word: got valid=%b data=%h expected 1 %h", bus.DATA_OUT_VALID, bus.DATA_OUT, PAT);
        end
        for (int i = 0; i < 20; i++) begin
            drive_cycle(1'b0, 1'b0, '0, 1'b0);
            if (TRAINING === 1'b1) th++;
        end
        vectors++;
        if (th != TW) begin
            miscompares++;
            $display("[TB] FAIL training_length: got %0d expected %0d", th, TW);
        end
        vectors++;
        if (FILL_CNT !== 16'd6) begin
            miscompares++;
            $display("[TB] FAIL fill_count: got %0d expected 6", FILL_CNT);
        end
    endtask

    task automatic test_payload();
        drive_cycle(1'b0, 1'b0, 80'd1, 1'b1);
        drive_cycle(1'b0, 1'b0, 80'd2, 1'b1);
        vectors++;
        if (bus.DATA_OUT !== 80'd1) begin
            miscompares++;
            $display("[TB] FAIL payload_1: got %h expected 1", bus.DATA_OUT);
        end
        drive_cycle(1'b0, 1'b0, 80'd3, 1'b1);
        vectors++;
        if (bus.DATA_OUT !== 80'd2) begin
            miscompares++;
            $display("[TB] FAIL payload_2: got %h expected 2", bus.DATA_OUT);
        end
        drive_cycle(1'b0, 1'b0, '0, 1'b0);
        vectors++;
        if (bus.DATA_OUT !== 80'd3 || PAYLOAD_CNT !== 16'd3) begin
            miscompares++;
            $display("[TB] FAIL payload_3: got %h cnt %0d expected 3 cnt 3", bus.DATA_OUT, PAYLOAD_CNT);
        end
        for (int i = 0; i < 2; i++) drive_cycle(1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic test_offset();
        OFFSET = 3'd3;
        MASK   = '0;
        drive_cycle(1'b1, 1'b0, '0, 1'b0);
        OFFSET = 3'd0;
        for (int i = 0; i < TW; i++) drive_cycle(1'b0, 1'b0, '0, 1'b0);
        drive_cycle(1'b0, 1'b0, 80'd0, 1'b1);
        drive_cycle(1'b0, 1'b0, 80'd1, 1'b1);
        drive_cycle(1'b0, 1'b0, 80'd0, 1'b1);
        vectors++;
        if (bus.DATA_OUT !== 80'h8) begin
            miscompares++;
            $display("[TB] FAIL offset_shift: got %h expected 8", bus.DATA_OUT);
        end
        drive_cycle(1'b0, 1'b0, '0, 1'b0);
        vectors++;
        if (bus.DATA_OUT !== 80'h0 || bus.DATA_OUT_VALID !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL offset_carry: got valid=%b data=%h expected 1 0", bus.DATA_OUT_VALID, bus.DATA_OUT);
        end
        drive_cycle(1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic test_mask();
        OFFSET = 3'd0;
        MASK   = '1;
        drive_cycle(1'b1, 1'b0, '0, 1'b0);
        MASK = '0;
        drive_cycle(1'b0, 1'b0, '0, 1'b0);
        drive_cycle(1'b0, 1'b0, '0, 1'b0);
        vectors++;
        if (bus.DATA_OUT !== ~PAT) begin
            miscompares++;
            $display("[TB] FAIL mask_train: got %h expected %h", bus.DATA_OUT, ~PAT);
        end
        for (int i = 0; i < TW - 1; i++) drive_cycle(1'b0, 1'b0, '0, 1'b0);
        drive_cycle(1'b0, 1'b0, 80'h1234, 1'b1);
        drive_cycle(1'b0, 1'b0, '0, 1'b0);
        vectors++;
        if (bus.DATA_OUT !== ~80'h1234) begin
            miscompares++;
            $display("[TB] FAIL mask_payload: got %h expected %h", bus.DATA_OUT, ~80'h1234);
        end
        drive_cycle(1'b0, 1'b1, '0, 1'b0);
        for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b0, '0, 1'b0);
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL mask_drain: got %0d words pending expected 0", q.size());
        end
    endtask

    task automatic test_stop();
        valid_seen = 0;
        ready_seen = 0;
        OFFSET = 3'd0;
        MASK   = '0;
        drive_cycle(1'b1, 1'b0, '0, 1'b0);
        for (int i = 0; i < 5; i++) drive_cycle(1'b0, 1'b0, 80'hAB, 1'b1);
        drive_cycle(1'b0, 1'b1, 80'hAB, 1'b1);
        for (int i = 0; i < 4; i++) drive_cycle(1'b0, 1'b0, 80'hAB, 1'b1);
        vectors++;
        if (valid_seen != 6 || ready_seen || TRAINING !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL stop_in_train: got words=%0d ready_seen=%0d training=%b expected 6 0 0",
                     valid_seen, ready_seen, TRAINING);
        end
        valid_seen = 0;
        drive_cycle(1'b1, 1'b1, '0, 1'b0);
        for (int i = 0; i < 4; i++) drive_cycle(1'b0, 1'b0, '0, 1'b0);
        vectors++;
        if (valid_seen != 0 || TRAINING !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL start_stop_same: got words=%0d training=%b expected 0 0", valid_seen, TRAINING);
        end
    endtask

    task automatic test_fill_wrap_and_reset();
        OFFSET = 3'd0;
        MASK   = '0;
        drive_cycle(1'b1, 1'b0, '0, 1'b0);
        for (int i = 0; i < TW; i++) drive_cycle(1'b0, 1'b0, '0, 1'b0);
        for (int i = 0; i < 65535; i++) drive_cycle(1'b0, 1'b0, '0, 1'b0);
        vectors++;
        if (FILL_CNT !== 16'hFFFF) begin
            miscompares++;
            $display("[TB] FAIL fill_preset: got %h expected ffff", FILL_CNT);
        end
        drive_cycle(1'b0, 1'b0, '0, 1'b0);
        vectors++;
        if (FILL_CNT !== 16'h0000) begin
            miscompares++;
            $display("[TB] FAIL fill_wrap: got %h expected 0000", FILL_CNT);
        end
        drive_cycle(1'b0, 1'b0, 80'hDEAD, 1'b1);
        drive_cycle(1'b0, 1'b0, 80'hBEEF, 1'b1);
        #2;
        RESET_N = 1'b0;
        #1;
        expect_zero_outputs("reset_midstream");
        model_reset();
        @(posedge USER_CLK);
        #1;
        expect_zero_outputs("reset_held");
        @(negedge USER_CLK);
        RESET_N = 1'b1;
        @(posedge USER_CLK);
        #1;
        valid_seen = 0;
        for (int i = 0; i < 5; i++) drive_cycle(1'b0, 1'b0, 80'h55, 1'b1);
        vectors++;
        if (valid_seen != 0) begin
            miscompares++;
            $display("[TB] FAIL post_reset_idle: got %0d valid words expected 0", valid_seen);
        end
        drive_cycle(1'b1, 1'b0, '0, 1'b0);
        for (int i = 0; i < 4; i++) drive_cycle(1'b0, 1'b0, '0, 1'b0);
        drive_cycle(1'b0, 1'b1, '0, 1'b0);
        for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b0, '0, 1'b0);
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL restart_drain: got %0d words pending expected 0", q.size());
        end
    endtask

    initial begin
        bus.DATA_IN       = '0;
        bus.DATA_IN_VALID = 1'b0;
        model_reset();
        test_reset();
        test_training();
        test_payload();
        test_offset();
        test_mask();
        test_stop();
        test_fill_wrap_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #5ms;
        $display("[TB] FAIL watchdog: got no completion by 5 ms expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
